// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline registers of the 5-stage MIPS core.
// Holds the stage occupancy encoding used by pipe_stage_reg.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Encoding of a MIPS NOP (sll $0,$0,0); flushed instruction slots collapse to this.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the optional pipeline stage performance counters.
// Counts cycles with inc=1 and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != MAX_VAL)) begin
            value <= value + ONE_VAL;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic 2-entry skid-buffer pipeline register with valid/ready handshake and synchronous flush.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_STAGE_PERF_EN is defined.
//
// Handshake: a payload moves across a port only in a cycle where both valid and ready are high
// at the rising clock edge; valid must be held with stable data until accepted, and ready here is
// a pure function of the state flop so it never depends combinationally on out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  FLUSH_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_DATA;
            skid_q  <= FLUSH_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Any coincident out_fire has already been seen downstream; only held data dies.
            state_d = EMPTY;
            main_d  = FLUSH_DATA;
            skid_d  = FLUSH_DATA;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = FLUSH_DATA;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = FLUSH_DATA;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = FLUSH_DATA;
                    skid_d  = FLUSH_DATA;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & (state_q != EMPTY);

    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .value (stall_cnt)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .value (flush_cnt)
    );
`else
    // No counters in this build; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: table-driven handshake vectors plus async reset
// and (when PIPE_STAGE_PERF_EN is defined) performance counter sequences.
module tb_pipe_stage_reg;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  flush_cnt;
`endif

    int n_cmp;
    int n_err;

    pipe_stage_reg #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        string        name;
        logic         iv;
        logic [W-1:0] d;
        logic         fl;
        logic         ordy;
        logic         e_ov;
        logic         e_ir;
        logic [W-1:0] e_od;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic iv, logic [W-1:0] d, logic fl, logic ordy,
                                logic e_ov, logic e_ir, logic [W-1:0] e_od);
        vec_t v;
        v.name = name; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od;
        vecs.push_back(v);
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, return on the next falling edge.
    task automatic step(logic iv, logic [W-1:0] d, logic fl, logic ordy);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(string name, logic e_ov, logic e_ir, logic [W-1:0] e_od);
        check({name, ".out_valid"}, W'(out_valid), W'(e_ov));
        check({name, ".in_ready"},  W'(in_ready),  W'(e_ir));
        check({name, ".out_data"},  out_data,      e_od);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Stream: each accepted word shows up after one edge, no bubbles.
        add("stream1", 1, 64'h1, 0, 1, 1, 1, 64'h1);
        add("stream2", 1, 64'h2, 0, 1, 1, 1, 64'h2);
        add("stream3", 1, 64'h3, 0, 1, 1, 1, 64'h3);
        add("stream4", 1, 64'h4, 0, 1, 1, 1, 64'h4);
        add("drain",   0, 64'h0, 0, 1, 0, 1, 64'h0);
        // Stall: two accepts fill both slots, third offer is ignored.
        add("stall_a", 1, 64'hA, 0, 0, 1, 1, 64'hA);
        add("stall_b", 1, 64'hB, 0, 0, 1, 0, 64'hA);
        add("stall_x", 1, 64'hD, 0, 0, 1, 0, 64'hA);
        add("rel_a",   0, 64'h0, 0, 1, 1, 1, 64'hB);
        add("rel_b",   0, 64'h0, 0, 1, 0, 1, 64'h0);
        // FULL with in_valid high while draining: in_ready=0 so 0xE is not taken.
        add("f2_1",    1, 64'h21, 0, 0, 1, 1, 64'h21);
        add("f2_2",    1, 64'h22, 0, 0, 1, 0, 64'h21);
        add("f2_drn",  1, 64'hE,  0, 1, 1, 1, 64'h22);
        add("f2_pass", 1, 64'h23, 0, 1, 1, 1, 64'h23);
        add("f2_end",  0, 64'h0,  0, 1, 0, 1, 64'h0);
        // Flush in FULL with an incoming 0xC.
        add("fl_1",    1, 64'h31, 0, 0, 1, 1, 64'h31);
        add("fl_2",    1, 64'h32, 0, 0, 1, 0, 64'h31);
        add("fl_c",    1, 64'hC,  1, 0, 0, 1, 64'h0);
        add("fl_idle", 0, 64'h0,  0, 1, 0, 1, 64'h0);
        // Flush in ONE with coincident out_fire and incoming data; flush in EMPTY with data.
        add("fo_1",    1, 64'h41, 0, 0, 1, 1, 64'h41);
        add("fo_fl",   1, 64'h42, 1, 1, 0, 1, 64'h0);
        add("fe_fl",   1, 64'h43, 1, 1, 0, 1, 64'h0);
        add("after",   1, 64'h44, 0, 1, 1, 1, 64'h44);
        add("hold",    0, 64'h0,  0, 0, 1, 1, 64'h44);
        add("fin",     0, 64'h0,  0, 1, 0, 1, 64'h0);

        // ---------------- reset ----------------
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 1'b1, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 1'b0, 1'b1, 64'h0);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].ordy);
            check_outs(vecs[i].name, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_od);
        end

        // ---------------- async reset mid-cycle while FULL ----------------
        step(1, 64'h51, 0, 0);
        step(1, 64'h52, 0, 0);
        check_outs("ar_full", 1'b1, 1'b0, 64'h51);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_outs("ar_now", 1'b0, 1'b1, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 64'h0, 0, 1);
        check_outs("ar_after", 1'b0, 1'b1, 64'h0);

`ifdef PIPE_STAGE_PERF_EN
        // ---------------- performance counters ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("perf_rst_stall", W'(stall_cnt), W'(32'd0));
        check("perf_rst_flush", W'(flush_cnt), W'(32'd0));
        step(1, 64'h61, 0, 0);
        repeat (5) step(0, 64'h0, 0, 0);
        step(0, 64'h0, 1, 1);
        step(0, 64'h0, 1, 1);
        check("perf_stall5", W'(stall_cnt), W'(32'd5));
        check("perf_flush1", W'(flush_cnt), W'(32'd1));
        step(1, 64'h62, 0, 0);
        force dut.u_stall_cnt.value = 32'hFFFF_FFFE;
        #1 release dut.u_stall_cnt.value;
        repeat (3) step(0, 64'h0, 0, 0);
        check("perf_sat", W'(stall_cnt), W'(32'hFFFF_FFFF));
        step(0, 64'h0, 1, 0);
        check("perf_noclr", W'(stall_cnt), W'(32'hFFFF_FFFF));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
